// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: drains the 17-bit LCD write FIFO onto an 8080-style parallel LCD bus
// Ports: clk/rst_n (sync, active-low) | rempty/rdata/rinc: FIFO read side (fall-through)
//        lcd_cs_n/lcd_rs/lcd_wr_n/lcd_rd_n/lcd_data/lcd_rst_n: registered LCD bus
//        busy (state != IDLE), word_cnt (words sent, wraps)
// Option: LCD_HWRST_EN adds a post-reset LCD hardware reset pulse and settle wait
module lcd_bus_writer #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2,
  parameter int CS_HOLD = 3
`ifdef LCD_HWRST_EN
  ,
  parameter int RST_LOW  = 16,
  parameter int RST_WAIT = 64
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rempty,
  input  logic [16:0] rdata,
  output logic        rinc,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_data,
  output logic        lcd_rst_n,
  output logic        busy,
  output logic [15:0] word_cnt
);
`ifdef LCD_HWRST_EN
  typedef enum logic [2:0] {IDLE, SETUP, WR_LO, WR_HI, HOLD, HWRST, HWWAIT} state_e;
  localparam state_e     S_RST = HWRST;
  localparam logic [7:0] C_RST = 8'(RST_LOW - 1);
  localparam logic       L_RST = 1'b0;
`else
  typedef enum logic [2:0] {IDLE, SETUP, WR_LO, WR_HI, HOLD} state_e;
  localparam state_e     S_RST = IDLE;
  localparam logic [7:0] C_RST = '0;
  localparam logic       L_RST = 1'b1;
`endif
  localparam logic [7:0] C_WL = 8'(WR_LOW - 1);
  localparam logic [7:0] C_WH = 8'(WR_HIGH - 1);
  localparam logic [7:0] C_CH = 8'(CS_HOLD - 1);
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, dec;
  logic        cs_q, cs_d, rs_q, rs_d, wr_q, wr_d, lrst_q, lrst_d;
  logic [15:0] data_q, data_d, wcnt_q, wcnt_d;
  assign dec       = cnt_q - 8'd1;
  assign rinc      = !rempty && (state_q == IDLE || state_q == HOLD || (state_q == WR_HI && cnt_q == '0));
  assign busy      = state_q != IDLE;
  assign lcd_cs_n  = cs_q;
  assign lcd_rs    = rs_q;
  assign lcd_wr_n  = wr_q;
  assign lcd_rd_n  = 1'b1;
  assign lcd_data  = data_q;
  assign word_cnt  = wcnt_q;
`ifdef LCD_HWRST_EN
  assign lcd_rst_n = lrst_q;
`else
  assign lcd_rst_n = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= C_RST;
      cs_q    <= 1'b1;
      rs_q    <= 1'b1;
      wr_q    <= 1'b1;
      data_q  <= '0;
      wcnt_q  <= '0;
      lrst_q  <= L_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      rs_q    <= rs_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      lrst_q  <= lrst_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    rs_d    = rs_q;
    wr_d    = wr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    lrst_d  = lrst_q;
    case (state_q)
      SETUP: begin
        wr_d    = 1'b0;
        cnt_d   = C_WL;
        state_d = WR_LO;
      end
      WR_LO: begin
        cnt_d = dec;
        if (cnt_q == '0) begin
          wr_d    = 1'b1;
          cnt_d   = C_WH;
          state_d = WR_HI;
        end
      end
      WR_HI: begin
        cnt_d = dec;
        if (cnt_q == '0) begin
          cnt_d   = C_CH;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = dec;
        if (cnt_q == '0) begin
          cs_d    = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef LCD_HWRST_EN
      HWRST: begin
        cnt_d = dec;
        if (cnt_q == '0) begin
          lrst_d  = 1'b1;
          cnt_d   = 8'(RST_WAIT - 1);
          state_d = HWWAIT;
        end
      end
      HWWAIT: begin
        cnt_d   = dec;
        state_d = cnt_q == '0 ? IDLE : HWWAIT;
      end
`endif
      default: ;
    endcase
    // a pop overrides the WR_HI->HOLD and HOLD->IDLE transitions, keeping CS low back-to-back
    if (rinc) begin
      data_d  = rdata[15:0];
      rs_d    = rdata[16];
      cs_d    = 1'b0;
      wcnt_d  = wcnt_q + 16'd1;
      state_d = SETUP;
    end
  end
endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: FIFO model + scoreboard bench for lcd_bus_writer
module tb_lcd_bus_writer;
  localparam int WR_LOW = 2, WR_HIGH = 2, CS_HOLD = 3;
`ifdef LCD_HWRST_EN
  localparam logic HW = 1'b1;
`else
  localparam logic HW = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, rempty = 1'b1, rinc;
  logic [16:0] rdata = '0;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, busy;
  logic [15:0] lcd_data, word_cnt;
  int          checks = 0, errors = 0, cyc = 0, pops = 0, cs_rises = 0, last_tail = 0, low = 0, tail = 0;
  logic        prev_wr = 1'b1, prev_cs = 1'b1;
  logic [16:0] fifo[$], exp_q[$];
  int          pop_cyc[$];
  typedef struct {logic [16:0] w; logic rs; logic [15:0] data;} vec_t;
  vec_t tv[5];

  lcd_bus_writer dut (
    .clk(clk), .rst_n(rst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
    .lcd_data(lcd_data), .lcd_rst_n(lcd_rst_n), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // FIFO read side: pop on rinc at the clock edge, pushing the popped word to the scoreboard
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("rinc_while_empty", 32'(rinc && fifo.size() == 0), 32'd0);
      if (rinc && fifo.size() != 0) begin
        exp_q.push_back(fifo.pop_front());
        pop_cyc.push_back(cyc);
        pops++;
      end
    end
  end

  // bus monitor: scoreboard compare on every wr_n rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_wr = 1'b1;
      prev_cs = 1'b1;
      low = 0;
      tail = 0;
    end else begin
      if (!lcd_wr_n) begin
        low++;
        chk("cs_during_wr", 32'(lcd_cs_n), 32'd0);
      end
      if (!prev_wr && lcd_wr_n) begin
        chk("wr_low_cycles", 32'(low), 32'(WR_LOW));
        low = 0;
        tail = 1;
        if (exp_q.size() == 0) chk("sb_unexpected_write", 32'd1, 32'd0);
        else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("sb_rs", 32'(lcd_rs), 32'(e[16]));
          chk("sb_data", 32'(lcd_data), 32'(e[15:0]));
        end
      end else if (lcd_wr_n && !lcd_cs_n) tail++;
      if (!prev_cs && lcd_cs_n) begin
        cs_rises++;
        last_tail = tail;
      end
      prev_wr = lcd_wr_n;
      prev_cs = lcd_cs_n;
    end
    rempty = fifo.size() == 0;
    rdata  = rempty ? 17'h0 : fifo[0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (!busy && rempty && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    tick(1);
  endtask

  task automatic wait_pop(input int n);
    int p0;
    p0 = pops;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (pops != p0) break;
    end
    chk("pop_timeout", 32'(pops != p0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int wexp, c0, cr0, p0, rl, bad;
    tv[0] = '{17'h0_002A, 1'b0, 16'h002A};
    tv[1] = '{17'h0_002B, 1'b0, 16'h002B};
    tv[2] = '{17'h1_ABCD, 1'b1, 16'hABCD};
    tv[3] = '{17'h1_0000, 1'b1, 16'h0000};
    tv[4] = '{17'h1_FFFF, 1'b1, 16'hFFFF};
    tick(3);
    @(negedge clk);
    #1;
    chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rst_rs", 32'(lcd_rs), 32'd1);
    chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("rst_rd_n", 32'(lcd_rd_n), 32'd1);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'(HW));
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_lcd_rst_n", 32'(lcd_rst_n), 32'(!HW));
    tick(1);
    wexp = 0;
`ifdef LCD_HWRST_EN
    fifo.push_back(17'h1_5555);
    rst_n = 1'b1;
    c0 = cyc;
    rl = 0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      rl += int'(!lcd_rst_n);
      bad += int'(busy !== 1'b1 || rinc !== 1'b0 || lcd_cs_n !== 1'b1);
    end
    chk("hw_rst_low_cycles", 32'(rl), 32'd16);
    chk("hw_busy_no_pop", 32'(bad), 32'd0);
    wait_pop(10);
    chk("hw_first_pop_cycle", 32'(pop_cyc.size() ? pop_cyc[0] - c0 : -1), 32'd81);
    wait_idle(60);
    wexp = 1;
    chk("hw_word_cnt", 32'(word_cnt), 32'(wexp));
`else
    rst_n = 1'b1;
    tick(1);
`endif
    // single command: pop latency and wr_n fall two edges after rempty falls
    fifo.push_back(17'h0_002A);
    tick(1);
    chk("lat_setup_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("lat_setup_cs_n", 32'(lcd_cs_n), 32'd0);
    chk("lat_setup_rs", 32'(lcd_rs), 32'd0);
    chk("lat_setup_data", 32'(lcd_data), 32'h2A);
    tick(1);
    chk("lat_wr_fall", 32'(lcd_wr_n), 32'd0);
    wait_idle(60);
    wexp++;
    chk("single_word_cnt", 32'(word_cnt), 32'(wexp));
    chk("single_cs_tail", 32'(last_tail), 32'(WR_HIGH + CS_HOLD));
    for (int i = 0; i < 5; i++) begin
      fifo.push_back(tv[i].w);
      wait_idle(60);
      wexp++;
      chk("vec_rs", 32'(lcd_rs), 32'(tv[i].rs));
      chk("vec_data", 32'(lcd_data), 32'(tv[i].data));
      chk("vec_word_cnt", 32'(word_cnt), 32'(wexp));
      chk("vec_cs_tail", 32'(last_tail), 32'(WR_HIGH + CS_HOLD));
    end
    // burst of three: pops 5 cycles apart, single CS window
    cr0 = cs_rises;
    pop_cyc.delete();
    fifo.push_back(17'h0_002C);
    fifo.push_back(17'h1_F800);
    fifo.push_back(17'h1_07E0);
    wait_idle(100);
    wexp += 3;
    chk("burst_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("burst_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd5);
      chk("burst_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd5);
    end
    chk("burst_cs_rises", 32'(cs_rises - cr0), 32'd1);
    chk("burst_word_cnt", 32'(word_cnt), 32'(wexp));
    // refill one cycle into HOLD: pop from HOLD, CS never released in between
    cr0 = cs_rises;
    pop_cyc.delete();
    fifo.push_back(17'h1_AAAA);
    wait_pop(20);
    tick(6);
    fifo.push_back(17'h1_5A5A);
    wait_idle(100);
    wexp += 2;
    chk("hold_pops", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) chk("hold_gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'd7);
    chk("hold_cs_rises", 32'(cs_rises - cr0), 32'd1);
    chk("hold_word_cnt", 32'(word_cnt), 32'(wexp));
    // reset during WR_LO aborts the word
    fifo.push_back(17'h1_1234);
    wait_pop(20);
    tick(1);
    chk("abort_in_wr_lo", 32'(lcd_wr_n), 32'd0);
    fifo.push_back(17'h0_0055);
    rst_n = 1'b0;
    tick(1);
    chk("abort_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("abort_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("abort_data", 32'(lcd_data), 32'd0);
    chk("abort_word_cnt", 32'(word_cnt), 32'd0);
    p0 = pops;
    rst_n = 1'b1;
    wait_idle(200);
    chk("abort_repop", 32'(pops - p0), 32'd1);
    chk("abort_next_rs", 32'(lcd_rs), 32'd0);
    chk("abort_next_data", 32'(lcd_data), 32'h55);
    chk("abort_word_cnt_after", 32'(word_cnt), 32'd1);
    // word counter wrap
    force dut.wcnt_q = 16'hFFFF;
    tick(1);
    release dut.wcnt_q;
    tick(1);
    chk("wrap_preload", 32'(word_cnt), 32'hFFFF);
    fifo.push_back(17'h1_0F0F);
    wait_idle(60);
    chk("wrap_zero", 32'(word_cnt), 32'd0);
    fifo.push_back(17'h0_002B);
    wait_idle(60);
    chk("wrap_one", 32'(word_cnt), 32'd1);
    // empty FIFO stays idle
    p0 = pops;
    tick(20);
    chk("empty_no_pop", 32'(pops - p0), 32'd0);
    chk("empty_rinc", 32'(rinc), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_cs_n", 32'(lcd_cs_n), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
